// File: rtl/viterbi_dec_k3_if.sv
// Symbol-in / decoded-bit-out bundle between the channel front end and the Viterbi decoder.
interface viterbi_dec_k3_if #(
    parameter int PM_WIDTH = 6
);
    logic                sym_valid;
    logic [1:0]          sym_in;
    logic                bit_valid;
    logic                bit_out;
    logic [1:0]          best_state;
    logic [PM_WIDTH-1:0] best_metric;

    modport master (
        output sym_valid, sym_in,
        input  bit_valid, bit_out, best_state, best_metric
    );

    modport slave (
        input  sym_valid, sym_in,
        output bit_valid, bit_out, best_state, best_metric
    );
endinterface

// File: rtl/viterbi_dec_k3.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) code.
// Four-state ACS with saturating, min-normalised metrics and register-exchange survivors.
module viterbi_dec_k3 #(
    parameter int TB_DEPTH = 16,
    parameter int PM_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    viterbi_dec_k3_if.slave dec
);
    localparam int FILL_W = $clog2(TB_DEPTH + 1);
    localparam logic [PM_WIDTH-1:0] PM_MAX  = {PM_WIDTH{1'b1}};
    localparam logic [PM_WIDTH-1:0] PM_ZERO = {PM_WIDTH{1'b0}};
    localparam logic [PM_WIDTH-1:0] PM_INIT = {1'b1, {(PM_WIDTH-1){1'b0}}};
    localparam logic [3:0][PM_WIDTH-1:0] PM_RESET = {PM_INIT, PM_INIT, PM_INIT, PM_ZERO};
    localparam logic [3:0][TB_DEPTH-1:0] SURV_RESET = {(4*TB_DEPTH){1'b0}};
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(TB_DEPTH - 1);

    // Encoder output {c0,c1} for data bit u leaving state s={s1,s0}.
    function automatic logic [1:0] enc_sym(input logic u, input logic [1:0] s);
        return {u ^ s[1] ^ s[0], u ^ s[0]};
    endfunction

    function automatic logic [PM_WIDTH-1:0] branch_metric(input logic [1:0] rx,
                                                          input logic       u,
                                                          input logic [1:0] pred);
        logic [1:0] diff;
        diff = rx ^ enc_sym(u, pred);
        return PM_WIDTH'(diff[1]) + PM_WIDTH'(diff[0]);
    endfunction

    function automatic logic [PM_WIDTH-1:0] sat_add(input logic [PM_WIDTH-1:0] a,
                                                    input logic [PM_WIDTH-1:0] b);
        logic [PM_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PM_WIDTH] ? PM_MAX : sum[PM_WIDTH-1:0];
    endfunction

    logic [3:0][PM_WIDTH-1:0] pm_r;
    logic [3:0][TB_DEPTH-1:0] surv_r;
    logic [FILL_W-1:0]        fill_r;
    logic                     bit_valid_r;
    logic                     bit_out_r;
    logic [1:0]               best_state_r;
    logic [PM_WIDTH-1:0]      best_metric_r;

    logic [3:0][PM_WIDTH-1:0] cand0_s;
    logic [3:0][PM_WIDTH-1:0] cand1_s;
    logic [3:0][PM_WIDTH-1:0] acs_s;
    logic [3:0][PM_WIDTH-1:0] norm_s;
    logic [3:0]               sel_s;
    logic [3:0][TB_DEPTH-1:0] surv_new_s;
    logic [PM_WIDTH-1:0]      min01_s;
    logic [PM_WIDTH-1:0]      min23_s;
    logic [PM_WIDTH-1:0]      min_s;
    logic [PM_WIDTH-1:0]      best_metric_new_s;
    logic [1:0]               idx01_s;
    logic [1:0]               idx23_s;
    logic [1:0]               best_s;
    logic [FILL_W-1:0]        fill_new_s;
    logic                     full_s;

    // Add-compare-select per next state n={u,p1}; ties keep the s0=0 predecessor.
    always_comb begin
        cand0_s    = PM_RESET;
        cand1_s    = PM_RESET;
        acs_s      = PM_RESET;
        sel_s      = 4'b0000;
        surv_new_s = SURV_RESET;
        for (int n = 0; n < 4; n++) begin
            cand0_s[n] = sat_add(pm_r[{n[0], 1'b0}],
                                 branch_metric(dec.sym_in, n[1], {n[0], 1'b0}));
            cand1_s[n] = sat_add(pm_r[{n[0], 1'b1}],
                                 branch_metric(dec.sym_in, n[1], {n[0], 1'b1}));
            sel_s[n]   = (cand1_s[n] < cand0_s[n]);
            acs_s[n]   = sel_s[n] ? cand1_s[n] : cand0_s[n];
            surv_new_s[n] = {surv_r[{n[0], sel_s[n]}][TB_DEPTH-2:0], n[1]};
        end
    end

    // Minimum search (lowest index wins ties), normalisation and fill tracking.
    always_comb begin
        idx01_s = (acs_s[1] < acs_s[0]) ? 2'd1 : 2'd0;
        min01_s = (acs_s[1] < acs_s[0]) ? acs_s[1] : acs_s[0];
        idx23_s = (acs_s[3] < acs_s[2]) ? 2'd3 : 2'd2;
        min23_s = (acs_s[3] < acs_s[2]) ? acs_s[3] : acs_s[2];
        best_s  = (min23_s < min01_s) ? idx23_s : idx01_s;
        min_s   = (min23_s < min01_s) ? min23_s : min01_s;
        norm_s  = PM_RESET;
        for (int n = 0; n < 4; n++) begin
            norm_s[n] = acs_s[n] - min_s;
        end
        best_metric_new_s = sat_add(best_metric_r, min_s);
        fill_new_s = (fill_r == FILL_FULL) ? FILL_FULL : fill_r + FILL_ONE;
        full_s     = (fill_r >= FILL_LAST);
    end

    // State and output registers; clear beats a same-cycle symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_r          <= PM_RESET;
            surv_r        <= SURV_RESET;
            fill_r        <= FILL_ZERO;
            bit_valid_r   <= 1'b0;
            bit_out_r     <= 1'b0;
            best_state_r  <= 2'd0;
            best_metric_r <= PM_ZERO;
        end else if (clear) begin
            pm_r          <= PM_RESET;
            surv_r        <= SURV_RESET;
            fill_r        <= FILL_ZERO;
            bit_valid_r   <= 1'b0;
            bit_out_r     <= 1'b0;
            best_state_r  <= 2'd0;
            best_metric_r <= PM_ZERO;
        end else if (dec.sym_valid) begin
            pm_r          <= norm_s;
            surv_r        <= surv_new_s;
            fill_r        <= fill_new_s;
            bit_valid_r   <= full_s;
            bit_out_r     <= surv_new_s[best_s][TB_DEPTH-1];
            best_state_r  <= best_s;
            best_metric_r <= best_metric_new_s;
        end else begin
            bit_valid_r   <= 1'b0;
        end
    end

    assign dec.bit_valid   = bit_valid_r;
    assign dec.bit_out     = bit_out_r;
    assign dec.best_state  = best_state_r;
    assign dec.best_metric = best_metric_r;
endmodule

// File: tb/tb_viterbi_dec_k3.sv
// Directed bench for viterbi_dec_k3: reference encoder feeds symbols, decoded bits are
// compared against the transmitted data delayed by the traceback depth.
module tb_viterbi_dec_k3;
    localparam int TBD = 16;
    localparam int PMW = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    int         n_assert = 0;
    int         n_fail = 0;
    int         pulses = 0;
    int         n_sym = 0;
    logic [1:0] enc_st;
    logic       last_bit;
    logic       exp_data[$];
    logic [1:0] vec_sym [0:21];
    logic       vec_dat [0:21];

    viterbi_dec_k3_if #(.PM_WIDTH(PMW)) dif ();

    viterbi_dec_k3 #(.TB_DEPTH(TBD), .PM_WIDTH(PMW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .dec   (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_restart();
        enc_st   = 2'b00;
        exp_data.delete();
        n_sym    = 0;
        last_bit = 1'b0;
    endtask

    // Drive one cycle starting at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [1:0] s, input logic c);
        dif.sym_valid = v;
        dif.sym_in    = s;
        clear         = c;
        @(posedge clk);
        @(negedge clk);
        dif.sym_valid = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic send_sym(input logic [1:0] s, input logic u, input string tag);
        exp_data.push_back(u);
        n_sym++;
        step(1'b1, s, 1'b0);
        if (n_sym >= TBD) begin
            last_bit = exp_data[n_sym - TBD];
            chk({tag, "_valid"}, 32'(dif.bit_valid), 32'd1);
            chk({tag, "_bit"}, 32'(dif.bit_out), 32'(last_bit));
        end else begin
            chk({tag, "_valid"}, 32'(dif.bit_valid), 32'd0);
        end
        if (dif.bit_valid === 1'b1) pulses++;
    endtask

    task automatic send_bit(input logic u, input logic [1:0] err, input string tag);
        logic [1:0] s;
        s      = {u ^ enc_st[1] ^ enc_st[0], u ^ enc_st[0]} ^ err;
        enc_st = {u, enc_st[1]};
        send_sym(s, u, tag);
    endtask

    task automatic idle(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            step(1'b0, 2'($urandom_range(3, 0)), 1'b0);
            chk({tag, "_idle_valid"}, 32'(dif.bit_valid), 32'd0);
            chk({tag, "_idle_hold"}, 32'(dif.bit_out), 32'(last_bit));
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        dif.sym_valid = 1'b0;
        dif.sym_in    = 2'b00;
        model_restart();
        for (int i = 0; i < 22; i++) begin
            vec_sym[i] = 2'b00;
            vec_dat[i] = 1'b0;
        end
        // Data 1,0,1,1,0,0 encodes to 11,10,00,01,01,11; zeros afterwards give 00.
        vec_sym[0] = 2'b11; vec_dat[0] = 1'b1;
        vec_sym[1] = 2'b10; vec_dat[1] = 1'b0;
        vec_sym[2] = 2'b00; vec_dat[2] = 1'b1;
        vec_sym[3] = 2'b01; vec_dat[3] = 1'b1;
        vec_sym[4] = 2'b01; vec_dat[4] = 1'b0;
        vec_sym[5] = 2'b11; vec_dat[5] = 1'b0;

        #12;
        chk("reset_bit_valid", 32'(dif.bit_valid), 32'd0);
        chk("reset_bit_out", 32'(dif.bit_out), 32'd0);
        chk("reset_best_state", 32'(dif.best_state), 32'd0);
        chk("reset_best_metric", 32'(dif.best_metric), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, "post_reset");

        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            send_bit(1'b0, 2'b00, "zero");
            chk("zero_metric", 32'(dif.best_metric), 32'd0);
            chk("zero_state", 32'(dif.best_state), 32'd0);
        end
        chk("zero_pulses", 32'(pulses), 32'd25);

        step(1'b0, 2'b00, 1'b1);
        model_restart();
        for (int i = 0; i < 22; i++) begin
            send_sym(vec_sym[i], vec_dat[i], "clean");
            chk("clean_metric", 32'(dif.best_metric), 32'd0);
            if (i == 2) chk("clean_state_sym3", 32'(dif.best_state), 32'd2);
        end

        step(1'b0, 2'b00, 1'b1);
        model_restart();
        for (int i = 0; i < 22; i++) begin
            send_sym((i == 2) ? (vec_sym[i] ^ 2'b10) : vec_sym[i], vec_dat[i], "err1");
            chk("err1_metric", 32'(dif.best_metric), (i >= 2) ? 32'd1 : 32'd0);
        end

        step(1'b0, 2'b00, 1'b1);
        model_restart();
        for (int i = 0; i < 216; i++) begin
            logic       u;
            logic [1:0] err;
            u   = (i < 200) ? 1'($urandom_range(1, 0)) : 1'b0;
            err = ((i % 12) != 5) ? 2'b00 : (((i / 12) % 2) != 0) ? 2'b01 : 2'b10;
            send_bit(u, err, "rand");
            idle(int'($urandom_range(3, 0)), "rand");
        end

        step(1'b0, 2'b00, 1'b1);
        model_restart();
        for (int i = 0; i < 9; i++) begin
            send_bit(1'($urandom_range(1, 0)), 2'b00, "clr_pre");
        end
        step(1'b1, 2'b11, 1'b1);
        model_restart();
        chk("clr_bit_valid", 32'(dif.bit_valid), 32'd0);
        chk("clr_bit_out", 32'(dif.bit_out), 32'd0);
        chk("clr_best_metric", 32'(dif.best_metric), 32'd0);
        chk("clr_best_state", 32'(dif.best_state), 32'd0);
        for (int i = 0; i < 30; i++) begin
            send_bit(1'($urandom_range(1, 0)), 2'b00, "clr_post");
        end

        step(1'b0, 2'b00, 1'b1);
        model_restart();
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b1, (i == 4) ? 2'b01 : 2'b00, "ones");
        end
        chk("pre_rst_state", 32'(dif.best_state), 32'd3);
        chk("pre_rst_metric", 32'(dif.best_metric), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bit_valid", 32'(dif.bit_valid), 32'd0);
        chk("async_rst_bit_out", 32'(dif.bit_out), 32'd0);
        chk("async_rst_best_state", 32'(dif.best_state), 32'd0);
        chk("async_rst_best_metric", 32'(dif.best_metric), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_restart();
        idle(1, "post_async");
        for (int i = 0; i < 25; i++) begin
            send_bit(1'($urandom_range(1, 0)), 2'b00, "post_async");
            chk("post_async_metric", 32'(dif.best_metric), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
